// File: rtl/serial_add_seq_if.sv
// Bus between the serial adder sequencer, its requester and the external 1-bit full-adder cell.
// The master side is both the requester and the full-adder cell; the slave side is the sequencer.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;

    modport master (
        output start, a, b, cin, fa_s, fa_cout,
        input  busy, done, sum, cout, fa_a, fa_b, fa_cin
    );

    modport slave (
        input  start, a, b, cin, fa_s, fa_cout,
        output busy, done, sum, cout, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds an external full-adder cell LSB first over WIDTH cycles,
// recirculating its carry and assembling the WIDTH-bit sum plus final carry.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_seq_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Bit 0 of the sum shifter would be shifted out unread, so it is not stored.
    logic [WIDTH-1:1] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             run;
    logic [WIDTH-1:0] s_shifted;

    assign run       = (state_q == S_RUN);
    assign s_shifted = {bus.fa_s, s_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_sh_d  = s_shifted[WIDTH-1:1];
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = bus.fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_shifted;
                    cout_d  = bus.fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // The cell inputs are gated so the adder sees zeros whenever no bit is being processed.
    assign bus.fa_a   = run & a_sh_q[0];
    assign bus.fa_b   = run & b_sh_q[0];
    assign bus.fa_cin = run & carry_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=16 against an arithmetic reference.
module tb_serial_add_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic        sel16 = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_seq_if #(.WIDTH(8))  bus8();
    serial_add_seq_if #(.WIDTH(16)) bus16();

    assign bus8.start  = start & ~sel16;
    assign bus8.a      = op_a[7:0];
    assign bus8.b      = op_b[7:0];
    assign bus8.cin    = cin;
    assign bus16.start = start & sel16;
    assign bus16.a     = op_a[15:0];
    assign bus16.b     = op_b[15:0];
    assign bus16.cin   = cin;

    // Full-adder cells the sequencers drive.
    assign bus8.fa_s     = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
    assign bus8.fa_cout  = (bus8.fa_a & bus8.fa_b) | (bus8.fa_cin & (bus8.fa_a ^ bus8.fa_b));
    assign bus16.fa_s    = bus16.fa_a ^ bus16.fa_b ^ bus16.fa_cin;
    assign bus16.fa_cout = (bus16.fa_a & bus16.fa_b) | (bus16.fa_cin & (bus16.fa_a ^ bus16.fa_b));

    serial_add_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    logic        o_busy, o_done, o_cout, o_fa_a, o_fa_b, o_fa_cin;
    logic [31:0] o_sum;
    assign o_busy   = sel16 ? bus16.busy   : bus8.busy;
    assign o_done   = sel16 ? bus16.done   : bus8.done;
    assign o_cout   = sel16 ? bus16.cout   : bus8.cout;
    assign o_fa_a   = sel16 ? bus16.fa_a   : bus8.fa_a;
    assign o_fa_b   = sel16 ? bus16.fa_b   : bus8.fa_b;
    assign o_fa_cin = sel16 ? bus16.fa_cin : bus8.fa_cin;
    assign o_sum    = sel16 ? {16'd0, bus16.sum} : {24'd0, bus8.sum};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the carry entering bit k is bit k of the sum of the operands' low k bits.
    function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input int k);
        logic [32:0] mk;
        logic [32:0] t;
        mk = (33'd1 << k) - 33'd1;
        t  = (33'(a) & mk) + (33'(b) & mk) + 33'(c);
        return t[k];
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 50) begin
            tick();
            k++;
        end
        check_eq("idle_before_start", 64'(o_busy), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!o_done && k < 40) begin
            tick();
            k++;
        end
        check_eq(tag, 64'(o_done), 64'd1);
    endtask

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] mask;
        logic [32:0] ref_full;
        logic        seen;
        int          k;
        mask     = (33'd1 << w) - 33'd1;
        ref_full = (33'(a) & mask) + (33'(b) & mask) + 33'(c);
        wait_idle();
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        cin   = 1'($urandom);
        k     = 0;
        seen  = 1'b0;
        while (k <= w + 3) begin
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            if (k < w) begin
                check_eq("busy_run", 64'(o_busy), 64'd1);
                check_eq("fa_a_bit", 64'(o_fa_a), 64'(a[k]));
                check_eq("fa_b_bit", 64'(o_fa_b), 64'(b[k]));
                check_eq("fa_cin_bit", 64'(o_fa_cin), 64'(carry_into(a, b, c, k)));
            end
            tick();
            k++;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("latency", 64'(k), 64'(w));
        check_eq("sum", 64'(o_sum), 64'(ref_full & (mask >> 1 | (33'd1 << (w - 1)))));
        check_eq("cout", 64'(o_cout), 64'(ref_full[w]));
        check_eq("fa_zero_done", 64'({o_fa_a, o_fa_b, o_fa_cin}), 64'd0);
        tick();
        check_eq("done_pulse_fall", 64'(o_done), 64'd0);
        check_eq("busy_fall", 64'(o_busy), 64'd0);
        check_eq("fa_zero_idle", 64'({o_fa_a, o_fa_b, o_fa_cin}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int last_done;

        // Reset state for both widths.
        #23;
        check_eq("rst_busy8", 64'(o_busy), 64'd0);
        check_eq("rst_done8", 64'(o_done), 64'd0);
        check_eq("rst_sum8", 64'(o_sum), 64'd0);
        check_eq("rst_cout8", 64'(o_cout), 64'd0);
        check_eq("rst_fa8", 64'({o_fa_a, o_fa_b, o_fa_cin}), 64'd0);
        sel16 = 1'b1;
        #1;
        check_eq("rst_busy16", 64'(o_busy), 64'd0);
        check_eq("rst_sum16", 64'(o_sum), 64'd0);
        sel16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors.
        run_op(8, 32'h0F, 32'h01, 1'b0);
        check_eq("tp_0f_01_sum", 64'(o_sum), 64'h10);
        check_eq("tp_0f_01_cout", 64'(o_cout), 64'd0);
        run_op(8, 32'hFF, 32'h01, 1'b0);
        check_eq("tp_ff_01_sum", 64'(o_sum), 64'h00);
        check_eq("tp_ff_01_cout", 64'(o_cout), 64'd1);
        run_op(8, 32'hFF, 32'hFF, 1'b1);
        check_eq("tp_ff_ff_sum", 64'(o_sum), 64'hFF);
        check_eq("tp_ff_ff_cout", 64'(o_cout), 64'd1);

        // start held high: one acceptance per WIDTH+2 cycles, mid-run operand changes ignored.
        wait_idle();
        op_a      = 32'h05;
        op_b      = 32'h03;
        cin       = 1'b0;
        start     = 1'b1;
        n_done    = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 35; cyc++) begin
            tick();
            if (o_done) begin
                n_done++;
                check_eq("held_sum", 64'(o_sum), 64'h08);
                check_eq("held_cout", 64'(o_cout), 64'd0);
                if (last_done >= 0) check_eq("held_period", 64'(cyc - last_done), 64'd10);
                last_done = cyc;
            end
            if (o_busy && !o_done) begin
                op_a = $urandom;
                op_b = $urandom;
            end else begin
                op_a = 32'h05;
                op_b = 32'h03;
            end
        end
        check_eq("held_count", 64'(n_done), 64'd3);
        start = 1'b0;

        // start pulses in RUN and DONE are ignored; next start after one idle cycle is taken.
        wait_idle();
        op_a  = 32'h12;
        op_b  = 32'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_a  = 32'h77;
        op_b  = 32'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign_done");
        check_eq("ign_sum", 64'(o_sum), 64'h46);
        check_eq("ign_cout", 64'(o_cout), 64'd0);
        start = 1'b1;
        tick();
        check_eq("ign_done_busy", 64'(o_busy), 64'd0);
        tick();
        check_eq("reaccept_busy", 64'(o_busy), 64'd1);
        start = 1'b0;
        wait_done("reaccept_done");
        check_eq("reaccept_sum", 64'(o_sum), 64'h88);
        tick();

        // Asynchronous reset in the middle of a run.
        wait_idle();
        op_a  = 32'hAA;
        op_b  = 32'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(o_busy), 64'd0);
        check_eq("mid_rst_done", 64'(o_done), 64'd0);
        check_eq("mid_rst_sum", 64'(o_sum), 64'd0);
        check_eq("mid_rst_cout", 64'(o_cout), 64'd0);
        check_eq("mid_rst_fa", 64'({o_fa_a, o_fa_b, o_fa_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle", 64'(o_busy), 64'd0);
        run_op(8, 32'h01, 32'h01, 1'b0);
        check_eq("post_rst_sum", 64'(o_sum), 64'h02);
        check_eq("post_rst_cout", 64'(o_cout), 64'd0);

        // Random sweeps at both widths.
        for (int i = 0; i < 1000; i++) run_op(8, $urandom, $urandom, 1'($urandom));
        sel16 = 1'b1;
        #1;
        for (int i = 0; i < 1000; i++) run_op(16, $urandom, $urandom, 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
